// File: rtl/hour_format_module_pkg.sv
// ============================================================================
// Module      : hour_fmt_pkg
// Description : Shared defaults, chime state encoding and the 24 h -> 12 h
//               conversion helper for the hour formatter slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hour_fmt_pkg;

  localparam int unsigned HOUR_W_DEF        = 6;
  localparam int unsigned MID_HOUR_DEF      = 12;
  localparam int unsigned HOURS_PER_DAY_DEF = 24;

  // Chime sequencer state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RING = 2'd2;

  // 24 h hour to 12 h display value (1..mid). Multiples of mid map to mid,
  // so both midnight and noon show as 12.
  function automatic int unsigned to_12h(input int unsigned hour,
                                         input int unsigned mid);
    int unsigned r;
    r = hour % mid;
    return (r == 0) ? mid : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hour_format_module_if.sv
// ============================================================================
// Module      : hour_fmt_if
// Description : Bundles the hour formatter's data inputs and display/event
//               outputs. The slave modport belongs to the formatter, the
//               master modport to whoever drives the hour and reads results.
//   hour, mode_toggle, tick        : master -> slave
//   disp_hour, isam, mode24,
//   hour_err, noon_pulse,
//   midnight_pulse, chime          : slave -> master
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hour_fmt_if #(
  parameter int unsigned HOUR_W = hour_fmt_pkg::HOUR_W_DEF
);
  logic [HOUR_W-1:0] hour;
  logic              mode_toggle;
  logic              tick;
  logic [HOUR_W-1:0] disp_hour;
  logic              isam;
  logic              mode24;
  logic              hour_err;
  logic              noon_pulse;
  logic              midnight_pulse;
  logic              chime;

  modport slave (
    input  hour, mode_toggle, tick,
    output disp_hour, isam, mode24, hour_err, noon_pulse, midnight_pulse, chime
  );

  modport master (
    output hour, mode_toggle, tick,
    input  disp_hour, isam, mode24, hour_err, noon_pulse, midnight_pulse, chime
  );
endinterface

`default_nettype wire

// File: rtl/hour_format_module_chime.sv
// ============================================================================
// Module      : hour_chime_seq
// Description : Hour chime sequencer. On every change of the in-range hour it
//               loads the 12 h hour value and then emits one chime strobe per
//               tick until the count is exhausted.
//   clk, reset  : clock, asynchronous active-low reset
//   hour        : current hour (24 h)
//   hour_valid  : hour is within the legal range this cycle
//   armed       : at least one in-range hour has been seen since reset
//   tick        : pacing strobe
//   chime       : registered one-cycle chime strobe
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hour_chime_seq
  import hour_fmt_pkg::*;
#(
  parameter int unsigned HOUR_W   = HOUR_W_DEF,
  parameter int unsigned MID_HOUR = MID_HOUR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [HOUR_W-1:0] hour,
  input  logic              hour_valid,
  input  logic              armed,
  input  logic              tick,
  output logic              chime
);

  logic [1:0]        state_q,     state_d;
  logic [HOUR_W-1:0] cnt_q,       cnt_d;
  logic [HOUR_W-1:0] last_hour_q, last_hour_d;
  logic              chime_q,     chime_d;
  logic              hour_chg;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_hour_d = last_hour_q;
    hour_chg    = hour_valid && armed && (hour != last_hour_q);

    if (hour_valid) last_hour_d = hour;

    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_WAIT: if (tick) state_d = ST_RING;
      ST_RING: begin
        cnt_d   = cnt_q - HOUR_W'(1);
        state_d = (cnt_d != '0) ? ST_WAIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new hour overrides whatever is in flight and restarts the count.
    if (hour_chg) begin
      cnt_d   = HOUR_W'(to_12h(32'(hour), MID_HOUR));
      state_d = ST_WAIT;
    end

    chime_d = (state_d == ST_RING);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_hour_q <= '0;
      chime_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_hour_q <= last_hour_d;
      chime_q     <= chime_d;
    end
  end

  assign chime = chime_q;

endmodule

`default_nettype wire

// File: rtl/hour_format_module.sv
// ============================================================================
// Module      : hour_format_module
// Description : Registered hour formatter. Converts the 24 h hour count into a
//               12 h or 24 h display hour with AM flag, range error, and
//               one-cycle noon / midnight event pulses.
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   bus    : hour_fmt_if.slave (hour, mode_toggle, tick in; display/event out)
// Optional feature macro: HOUR_FORMAT_CHIME_EN enables the hour chime
// sequencer; without it chime is tied low and tick is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hour_format_module
  import hour_fmt_pkg::*;
#(
  parameter int unsigned HOUR_W        = HOUR_W_DEF,
  parameter int unsigned HOURS_PER_DAY = HOURS_PER_DAY_DEF,
  parameter int unsigned MID_HOUR      = MID_HOUR_DEF,
  parameter bit          DEFAULT_24H   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  hour_fmt_if.slave   bus
);

  localparam logic [HOUR_W-1:0] C_HPD = HOUR_W'(HOURS_PER_DAY);
  localparam logic [HOUR_W-1:0] C_MID = HOUR_W'(MID_HOUR);

  logic [HOUR_W-1:0] disp_hour_q, disp_hour_d;
  logic              isam_q,      isam_d;
  logic              mode24_q,    mode24_d;
  logic              hour_err_q,  hour_err_d;
  logic              noon_q,      noon_d;
  logic              midnight_q,  midnight_d;
  logic              prev_isam_q, prev_isam_d;
  logic              first_q,     first_d;
  logic              in_range;

  always_comb begin
    in_range    = (bus.hour < C_HPD);
    mode24_d    = mode24_q ^ bus.mode_toggle;
    hour_err_d  = !in_range;
    disp_hour_d = disp_hour_q;
    isam_d      = isam_q;
    noon_d      = 1'b0;
    midnight_d  = 1'b0;
    prev_isam_d = prev_isam_q;
    first_d     = first_q;

    if (in_range) begin
      isam_d      = (bus.hour < C_MID);
      // Uses the post-toggle mode so a toggle shows up with the same latency
      // as an hour change.
      disp_hour_d = mode24_d ? bus.hour
                             : HOUR_W'(to_12h(32'(bus.hour), MID_HOUR));
      // first suppresses an event on the very first sample after reset,
      // where prev_isam still holds its reset value.
      noon_d      =  prev_isam_q && !isam_d && !first_q;
      midnight_d  = !prev_isam_q &&  isam_d && !first_q;
      prev_isam_d = isam_d;
      first_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_hour_q <= '0;
      isam_q      <= 1'b0;
      mode24_q    <= DEFAULT_24H;
      hour_err_q  <= 1'b0;
      noon_q      <= 1'b0;
      midnight_q  <= 1'b0;
      prev_isam_q <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      disp_hour_q <= disp_hour_d;
      isam_q      <= isam_d;
      mode24_q    <= mode24_d;
      hour_err_q  <= hour_err_d;
      noon_q      <= noon_d;
      midnight_q  <= midnight_d;
      prev_isam_q <= prev_isam_d;
      first_q     <= first_d;
    end
  end

  assign bus.disp_hour      = disp_hour_q;
  assign bus.isam           = isam_q;
  assign bus.mode24         = mode24_q;
  assign bus.hour_err       = hour_err_q;
  assign bus.noon_pulse     = noon_q;
  assign bus.midnight_pulse = midnight_q;

`ifdef HOUR_FORMAT_CHIME_EN
  hour_chime_seq #(
    .HOUR_W   (HOUR_W),
    .MID_HOUR (MID_HOUR)
  ) u_chime (
    .clk        (clk),
    .reset      (reset),
    .hour       (bus.hour),
    .hour_valid (in_range),
    .armed      (!first_q),
    .tick       (bus.tick),
    .chime      (bus.chime)
  );
`else
  logic unused_tick;
  assign unused_tick = bus.tick;
  assign bus.chime   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hour_format_module.sv
// ============================================================================
// Module      : tb_hour_format_module
// Description : Self-checking bench for hour_format_module: table of directed
//               vectors plus hand-written chime / reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hour_format_module;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hour_fmt_if #(.HOUR_W(6)) bus ();

  hour_format_module dut (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus)
  );

  typedef struct {
    logic [5:0] hour;
    logic       tog;
    logic [5:0] disp;
    logic       isam;
    logic       err;
    logic       noon;
    logic       mid;
    logic       m24;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int h, input int t, input int d, input int am,
                              input int e, input int n, input int m, input int m24);
    vec_t v;
    v.hour = 6'(h); v.tog = 1'(t); v.disp = 6'(d); v.isam = 1'(am);
    v.err = 1'(e); v.noon = 1'(n); v.mid = 1'(m); v.m24 = 1'(m24);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic t);
    bus.tick = t;
    @(posedge clk);
    #1;
  endtask

  // One cycle; any chime seen must follow a tick sampled on that edge.
  task automatic chime_cyc(input logic t, inout int pulses);
    step(t);
    if (bus.chime) begin
      pulses++;
      chk("chime_align", int'(t), 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int seen;

    // hour, toggle, disp, isam, err, noon, mid, mode24
    add(0, 0, 12, 1, 0, 0, 0, 0);
    for (int h = 1; h <= 11; h++) add(h, 0, h, 1, 0, 0, 0, 0);
    add(12, 0, 12, 0, 0, 1, 0, 0);
    for (int h = 13; h <= 23; h++) add(h, 0, h - 12, 0, 0, 0, 0, 0);
    add(0,  0, 12, 1, 0, 0, 1, 0);   // 23 -> 0 midnight
    add(0,  0, 12, 1, 0, 0, 0, 0);   // hold: no repeat
    add(11, 0, 11, 1, 0, 0, 0, 0);
    add(12, 0, 12, 0, 0, 1, 0, 0);   // 11 -> 12 noon
    add(12, 0, 12, 0, 0, 0, 0, 0);   // hold: no repeat
    add(15, 0, 3,  0, 0, 0, 0, 0);
    add(15, 1, 15, 0, 0, 0, 0, 1);   // toggle to 24 h
    add(15, 0, 15, 0, 0, 0, 0, 1);
    add(15, 1, 3,  0, 0, 0, 0, 0);   // toggle back
    add(30, 0, 3,  0, 1, 0, 0, 0);   // out of range: hold
    add(7,  0, 7,  1, 0, 0, 1, 0);   // PM (from 15) -> AM
    add(7,  1, 7,  1, 0, 0, 0, 1);
    add(0,  0, 0,  1, 0, 0, 0, 1);   // 24 h shows 0
    add(23, 0, 23, 0, 0, 1, 0, 1);   // hour jump gives noon
    add(30, 1, 23, 0, 1, 0, 0, 0);   // toggle still acts when out of range
    add(23, 0, 11, 0, 0, 0, 0, 0);
    add(24, 0, 11, 0, 1, 0, 0, 0);   // first illegal value
    add(63, 0, 11, 0, 1, 0, 0, 0);
    add(11, 0, 11, 1, 0, 0, 1, 0);

    // ---- reset state and first sample -----------------------------------
    reset_n = 1'b0;
    bus.hour = 6'd5;
    bus.mode_toggle = 1'b0;
    bus.tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_disp",  int'(bus.disp_hour), 0);
    chk("rst_isam",  int'(bus.isam), 0);
    chk("rst_err",   int'(bus.hour_err), 0);
    chk("rst_mode24", int'(bus.mode24), 0);
    chk("rst_noon",  int'(bus.noon_pulse), 0);
    chk("rst_mid",   int'(bus.midnight_pulse), 0);
    chk("rst_chime", int'(bus.chime), 0);
    reset_n = 1'b1;
    step(1'b0);
    chk("first_disp", int'(bus.disp_hour), 5);
    chk("first_isam", int'(bus.isam), 1);
    chk("first_err",  int'(bus.hour_err), 0);
    chk("first_noon", int'(bus.noon_pulse), 0);
    chk("first_mid",  int'(bus.midnight_pulse), 0);
    step(1'b0);
    chk("first_mid2", int'(bus.midnight_pulse), 0);
    chk("first_noon2", int'(bus.noon_pulse), 0);

    // ---- table vectors --------------------------------------------------
    foreach (vecs[i]) begin
      bus.hour = vecs[i].hour;
      bus.mode_toggle = vecs[i].tog;
      step(1'b0);
      chk($sformatf("v%0d_disp", i),  int'(bus.disp_hour), int'(vecs[i].disp));
      chk($sformatf("v%0d_isam", i),  int'(bus.isam), int'(vecs[i].isam));
      chk($sformatf("v%0d_err", i),   int'(bus.hour_err), int'(vecs[i].err));
      chk($sformatf("v%0d_noon", i),  int'(bus.noon_pulse), int'(vecs[i].noon));
      chk($sformatf("v%0d_mid", i),   int'(bus.midnight_pulse), int'(vecs[i].mid));
      chk($sformatf("v%0d_mode24", i), int'(bus.mode24), int'(vecs[i].m24));
      chk($sformatf("v%0d_chime", i), int'(bus.chime), 0);
    end
    bus.mode_toggle = 1'b0;

`ifdef HOUR_FORMAT_CHIME_EN
    // ---- chime: 2 -> 3 gives three pulses -------------------------------
    reset_n = 1'b0;
    bus.hour = 6'd2;
    step(1'b0);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) chime_cyc(1'b0, pulses);
    bus.hour = 6'd3;
    for (int i = 0; i < 40; i++) chime_cyc(i % 8 == 7, pulses);
    chk("chime_count3", pulses, 3);

    // ---- restart: 3 -> 4 after the first pulse gives four more ---------
    bus.hour = 6'd2;
    step(1'b0);
    bus.hour = 6'd3;
    pulses = 0;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      chime_cyc(i % 8 == 7, pulses);
      if (pulses != 0) seen = 1;
    end
    chk("chime_first_seen", seen, 1);
    bus.hour = 6'd4;
    pulses = 0;
    for (int i = 0; i < 48; i++) chime_cyc(i % 8 == 7, pulses);
    chk("chime_restart4", pulses, 4);

    // ---- reset mid-sequence ---------------------------------------------
    bus.hour = 6'd5;
    pulses = 0;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      chime_cyc(i % 8 == 7, pulses);
      if (pulses != 0) seen = 1;
    end
    chk("chime_pre_rst", seen, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("chime_async_rst", int'(bus.chime), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 32; i++) chime_cyc(i % 8 == 7, pulses);
    chk("chime_idle_after_rst", pulses, 0);
`else
    // ---- chime disabled: never asserts, whatever tick and hour do -------
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) bus.hour = 6'd3;
      if (i == 12) bus.hour = 6'd4;
      step(i % 2 == 1);
      if (bus.chime) pulses++;
    end
    chk("chime_disabled", pulses, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
